stream_demultiplexer: RTL and testbench
=======================================

STREAM_DEMULTIPLEXER -- requirements
Module: stream_demultiplexer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bit width of one data word.
REQ-002 Parameter DATA_LINES, default 4, number of output lanes, legal range 1..32.
REQ-003 Parameter CNT_WIDTH, default 16, width of the drop counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  input word accepted this cycle when in_valid is also 1.
REQ-008 in_data  input  DATA_WIDTH  input word.
REQ-009 in_sel  input  DATA_LINES  multi-hot lane mask; bit i set routes the word to lane i.
REQ-010 out_valid  output  DATA_LINES  per-lane word present.
REQ-011 out_ready  input  DATA_LINES  per-lane consumer ready.
REQ-012 out_data  output  [DATA_LINES][DATA_WIDTH]  per-lane word, packed array.
REQ-013 drop_count  output  CNT_WIDTH  number of words accepted with in_sel == 0.

Function
REQ-014 Each lane shall hold a one-entry register (valid bit plus data word).
REQ-015 Lane i is free in a cycle when its valid bit is 0 or out_ready[i] is 1.
REQ-016 in_ready shall be 1 exactly when every lane with in_sel[i] = 1 is free; in_ready depends combinationally on in_sel and out_ready.
REQ-017 Acceptance shall be all-or-nothing: on in_valid & in_ready, every selected lane loads in_data and sets valid on the same edge. No partial broadcast state exists.
REQ-018 Latency shall be one cycle: a word accepted at edge N appears on out_data/out_valid after edge N.
REQ-019 Lane i shall clear valid on an edge where out_valid[i] & out_ready[i] and lane i is not loaded on that edge.
REQ-020 Simultaneous drain and load on one lane shall leave valid at 1 with the new word, giving full throughput of one word per cycle per lane.
REQ-021 While out_valid[i] = 1 and out_ready[i] = 0, out_data[i] shall hold stable.
REQ-022 Unselected lanes shall be unaffected by an input transfer.
REQ-023 in_valid with in_sel == 0 shall be accepted (in_ready = 1), discarded, and drop_count incremented by one.
REQ-024 drop_count shall saturate at all-ones and never wrap.
REQ-025 out_data of an empty lane shall retain its last value; consumers shall ignore it.
REQ-026 in_ready shall not depend on in_valid.

Reset
REQ-027 While reset = 1: out_valid = 0, out_data = 0, drop_count = 0, asynchronously.
REQ-028 Reset during operation shall discard all held words without handshake; the first transfer is possible on the first edge after reset deasserts.

Structure
REQ-029 Package demux_pkg shall hold the default CNT_WIDTH constant and the lane-count limit constant.
REQ-030 Sub-module lane_register (one-entry valid/data buffer with load, drain, async reset) shall be instantiated DATA_LINES times through a generate loop.
REQ-031 The drop counter and in_ready reduction shall live in stream_demultiplexer.

Verification
REQ-032 Unicast: DATA_LINES=4, all out_ready=1, in_sel=0010, in_data=0xA5A5A5A5 -> after one edge out_valid=0010, out_data[1]=0xA5A5A5A5.
REQ-033 Broadcast stall: lane 2 holds a word with out_ready[2]=0, then in_sel=0101 -> in_ready=0 and lane 0 stays empty; raise out_ready[2] -> both lanes load on the same edge.
REQ-034 Back-to-back: in_sel=1000 and out_ready[3]=1 for 8 cycles with data 1..8 -> lane 3 emits 1..8 on consecutive cycles, and in_ready stays 1.
REQ-035 Drop saturation: CNT_WIDTH=4, 20 words with in_sel=0 -> drop_count=15 and all out_valid=0.
REQ-036 Mid-operation reset: all lanes valid, assert reset asynchronously between edges -> out_valid=0 and drop_count=0 immediately, with no lane output after deassertion until a new word is accepted.
REQ-037 Hold: out_valid[0]=1 with out_ready[0]=0 for 5 cycles while other lanes transfer -> out_data[0] is unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the stream demultiplexer: default counter width and lane-count limit.
package demux_pkg;
    localparam int CNT_WIDTH_DEFAULT = 16;
    localparam int MAX_LINES         = 32;
endpackage

// File: rtl/lane_register.sv
// One-entry output buffer for a single lane: a valid bit plus a data word.
// A load wins over a drain, so a lane refilled while draining keeps streaming every cycle.
module lane_register #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            // The data word is left in place so an idle lane simply shows its last value.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/stream_demultiplexer.sv
// Routes each input word to every lane in a multi-hot mask, all-or-nothing.
// Words with an empty mask are accepted, discarded, and counted in a saturating counter.
module stream_demultiplexer
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_LINES = 4,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    input  logic [DATA_LINES-1:0]                 in_sel,
    output logic [DATA_LINES-1:0]                 out_valid,
    input  logic [DATA_LINES-1:0]                 out_ready,
    output logic [DATA_LINES-1:0][DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]                  drop_count
);
    if (DATA_LINES < 1 || DATA_LINES > MAX_LINES) begin : g_bad_lines
        $error("stream_demultiplexer: DATA_LINES out of range");
    end

    logic [DATA_LINES-1:0] w_free;
    logic [DATA_LINES-1:0] w_load;
    logic                  w_xfer;
    logic                  w_drop;
    logic [CNT_WIDTH-1:0]  r_drop_count;

    // A lane is free if empty or being drained this cycle; only selected lanes gate acceptance.
    assign w_free   = ~out_valid | out_ready;
    assign in_ready = &(~in_sel | w_free);
    assign w_xfer   = in_valid & in_ready;
    assign w_load   = {DATA_LINES{w_xfer}} & in_sel;
    assign w_drop   = w_xfer & (in_sel == '0);

    for (genvar i = 0; i < DATA_LINES; i++) begin : g_lane
        lane_register #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load[i]),
            .i_data (in_data),
            .i_ready(out_ready[i]),
            .o_valid(out_valid[i]),
            .o_data (out_data[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop && r_drop_count != '1) begin
            r_drop_count <= r_drop_count + CNT_WIDTH'(1);
        end
    end

    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_stream_demultiplexer.sv
// Directed bench for stream_demultiplexer: 4 lanes, 4-bit drop counter to reach saturation quickly.
module tb_stream_demultiplexer;
    localparam int DW = 32;
    localparam int NL = 4;
    localparam int CW = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_data;
    logic [NL-1:0]         in_sel;
    logic [NL-1:0]         out_valid;
    logic [NL-1:0]         out_ready;
    logic [NL-1:0][DW-1:0] out_data;
    logic [CW-1:0]         drop_count;

    int n_chk  = 0;
    int n_fail = 0;

    stream_demultiplexer #(
        .DATA_WIDTH(DW),
        .DATA_LINES(NL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_drop", 64'(drop_count), 64'h0);
        chk("rst_data0", 64'(out_data[0]), 64'h0);
        chk("rst_ready_nosel", 64'(in_ready), 64'h1);
        tick();
        reset = 1'b0;

        // Unicast to lane 1
        out_ready = 4'b1111;
        in_sel    = 4'b0010;
        in_data   = 32'hA5A5_A5A5;
        in_valid  = 1'b1;
        #1;
        chk("uni_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        chk("uni_valid", 64'(out_valid), 64'h2);
        chk("uni_data1", 64'(out_data[1]), 64'hA5A5_A5A5);
        tick();
        chk("uni_drain", 64'(out_valid), 64'h0);

        // Broadcast stall behind a blocked lane 2
        out_ready = 4'b1011;
        in_sel    = 4'b0100;
        in_data   = 32'h11;
        in_valid  = 1'b1;
        tick();
        in_sel   = 4'b0101;
        in_data  = 32'h22;
        #1;
        chk("bc_valid_l2", 64'(out_valid), 64'h4);
        chk("bc_stall_ready", 64'(in_ready), 64'h0);
        tick();
        chk("bc_l0_empty", 64'(out_valid), 64'h4);
        chk("bc_l2_held", 64'(out_data[2]), 64'h11);
        out_ready = 4'b1111;
        #1;
        chk("bc_unstall_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        chk("bc_both_valid", 64'(out_valid), 64'h5);
        chk("bc_data0", 64'(out_data[0]), 64'h22);
        chk("bc_data2", 64'(out_data[2]), 64'h22);
        tick();
        chk("bc_drain", 64'(out_valid), 64'h0);

        // Back-to-back stream on lane 3
        in_sel = 4'b1000;
        for (int k = 1; k <= 8; k++) begin
            in_data  = DW'(k);
            in_valid = 1'b1;
            #1;
            chk($sformatf("b2b_ready_%0d", k), 64'(in_ready), 64'h1);
            tick();
            chk($sformatf("b2b_valid_%0d", k), 64'(out_valid), 64'h8);
            chk($sformatf("b2b_data_%0d", k), 64'(out_data[3]), 64'(k));
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_drain", 64'(out_valid), 64'h0);

        // Lane 0 held while lane 1 streams
        in_sel   = 4'b0001;
        in_data  = 32'h5A;
        in_valid = 1'b1;
        out_ready = 4'b1110;
        tick();
        in_sel = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            in_data = 32'h100 + DW'(c);
            tick();
            chk($sformatf("hold_v0_%0d", c), 64'(out_valid[0]), 64'h1);
            chk($sformatf("hold_d0_%0d", c), 64'(out_data[0]), 64'h5A);
            chk($sformatf("hold_d1_%0d", c), 64'(out_data[1]), 64'h100 + 64'(c));
        end
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        tick();
        chk("hold_drain", 64'(out_valid), 64'h0);

        // Drop counter saturation
        in_sel   = 4'b0000;
        in_valid = 1'b1;
        #1;
        chk("drop_ready", 64'(in_ready), 64'h1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5) chk("drop_5", 64'(drop_count), 64'd5);
        end
        in_valid = 1'b0;
        chk("drop_sat", 64'(drop_count), 64'd15);
        chk("drop_no_valid", 64'(out_valid), 64'h0);
        tick();
        chk("drop_sat_hold", 64'(drop_count), 64'd15);

        // Mid-operation asynchronous reset
        out_ready = 4'b0000;
        in_sel    = 4'b1111;
        in_data   = 32'h77;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mrst_all_valid", 64'(out_valid), 64'hF);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'h0);
        chk("mrst_drop", 64'(drop_count), 64'h0);
        chk("mrst_data3", 64'(out_data[3]), 64'h0);
        @(posedge clk);
        #3;
        reset     = 1'b0;
        out_ready = 4'b1111;
        #1;
        chk("mrst_post_valid", 64'(out_valid), 64'h0);
        tick();
        chk("mrst_idle_valid", 64'(out_valid), 64'h0);
        in_sel   = 4'b0001;
        in_data  = 32'h99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mrst_new_valid", 64'(out_valid), 64'h1);
        chk("mrst_new_data", 64'(out_data[0]), 64'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
